// File: rtl/trig_coinc.sv
// trig_coinc: coincidence trigger with fixed-length output pulse and dead time; `TRIG_PRESCALE_EN adds a hit prescaler
module trig_coinc #(
  parameter int NIN = 8,
  parameter int NOUT = 16,
  parameter int TW = 8,
  localparam int CW = $clog2(NIN + 1)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [NIN-1:0]  coax_in,
  input  logic [NIN-1:0]  mask,
  input  logic [CW-1:0]   mult_thresh,
  input  logic [TW-1:0]   firingticks,
  input  logic [TW-1:0]   deadticks,
  input  logic            enable,
  input  logic            cnt_clr,
`ifdef TRIG_PRESCALE_EN
  input  logic [TW-1:0]   prescale,
`endif
  output logic [NOUT-1:0] coax_out,
  output logic            busy,
  output logic [31:0]     trig_count
);
  typedef enum logic [1:0] {IDLE, FIRING, DEAD} state_t;
  localparam int SW = TW + 2;
  state_t state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d, dead_q, dead_d, f_m1, d_len;
  logic [CW-1:0] mult;
  logic [NOUT-1:0] coax_q;
  logic busy_q;
  logic [31:0] count_q, count_d;
  logic hit, fire, psc_ok;
  // number of enabled channels currently asserted
  always_comb begin
    mult = '0;
    for (int i = 0; i < NIN; i++) mult = mult + CW'(coax_in[i] & mask[i]);
  end
  assign hit = enable && (mult_thresh != '0) && (mult >= mult_thresh);
`ifdef TRIG_PRESCALE_EN
  logic [TW-1:0] psc_q, psc_d;
  assign psc_ok = psc_q >= prescale;
  assign psc_d = (state_q == IDLE && hit) ? (psc_ok ? '0 : psc_q + TW'(1)) : psc_q;
  // prescale counter only advances on hits seen while idle
  always_ff @(posedge clk) begin
    if (!nrst) psc_q <= '0;
    else psc_q <= psc_d;
  end
`else
  assign psc_ok = 1'b1;
`endif
  assign fire = (state_q == IDLE) && hit && psc_ok;
  assign f_m1 = (firingticks == '0) ? '0 : SW'(firingticks) - SW'(1);
  assign d_len = {deadticks, 2'b00};
  assign count_d = cnt_clr ? {31'd0, fire} : (fire && count_q != '1) ? count_q + 32'd1 : count_q;
  // cnt_q holds remaining cycles minus one in the current timed state; durations are latched at fire
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dead_d = dead_q;
    if (state_q == IDLE) begin
      if (fire) begin
        state_d = FIRING;
        cnt_d = f_m1;
        dead_d = d_len;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - SW'(1);
    end else if (state_q == FIRING && dead_q != '0) begin
      state_d = DEAD;
      cnt_d = dead_q - SW'(1);
    end else begin
      state_d = IDLE;
    end
  end
  // state, timers, counter and registered outputs
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dead_q <= '0;
      count_q <= '0;
      coax_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dead_q <= dead_d;
      count_q <= count_d;
      coax_q <= {NOUT{state_d == FIRING}};
      busy_q <= state_d != IDLE;
    end
  end
  assign coax_out = coax_q;
  assign busy = busy_q;
  assign trig_count = count_q;
endmodule

// File: tb/tb_trig_coinc.sv
// tb_trig_coinc: randomized and directed checks of trig_coinc against a remaining-cycles reference model
module tb_trig_coinc;
  localparam int NIN = 8, NOUT = 16, TW = 8, CW = $clog2(NIN + 1);
  logic clk = 1'b0, nrst = 1'b0, enable = 1'b0, cnt_clr = 1'b0;
  logic [NIN-1:0] coax_in = '0, mask = '0;
  logic [CW-1:0] mult_thresh = '0;
  logic [TW-1:0] firingticks = '0, deadticks = '0, prescale = '0;
  logic [NOUT-1:0] coax_out;
  logic busy;
  logic [31:0] trig_count;
  int total = 0, bad = 0;
  int m_fire = 0, m_dead = 0, m_psc = 0;
  longint m_cnt = 0;

  trig_coinc #(.NIN(NIN), .NOUT(NOUT), .TW(TW)) dut (
    .clk(clk), .nrst(nrst), .coax_in(coax_in), .mask(mask), .mult_thresh(mult_thresh),
    .firingticks(firingticks), .deadticks(deadticks), .enable(enable), .cnt_clr(cnt_clr),
`ifdef TRIG_PRESCALE_EN
    .prescale(prescale),
`endif
    .coax_out(coax_out), .busy(busy), .trig_count(trig_count)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    int mult;
    bit idle, hit, go;
    mult = $countones(coax_in & mask);
    hit = enable && mult_thresh != 0 && mult >= int'(mult_thresh);
    idle = (m_fire == 0 && m_dead == 0);
    if (!nrst) begin
      m_fire = 0; m_dead = 0; m_cnt = 0; m_psc = 0;
      return;
    end
    go = idle && hit;
`ifdef TRIG_PRESCALE_EN
    if (idle && hit) begin
      if (m_psc >= int'(prescale)) m_psc = 0;
      else begin m_psc++; go = 0; end
    end
`endif
    if (cnt_clr) m_cnt = go;
    else if (go && m_cnt < 64'hFFFFFFFF) m_cnt++;
    if (m_fire > 0) m_fire--;
    else if (m_dead > 0) m_dead--;
    else if (go) begin
      m_fire = (firingticks == 0) ? 1 : int'(firingticks);
      m_dead = int'(deadticks) * 4;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    nrst = 0; coax_in = '0; cnt_clr = 0;
    cyc(); cyc();
    nrst = 1;
  endtask

  task automatic test_reset();
    nrst = 0; coax_in = '1; mask = '1; mult_thresh = 1; enable = 1; firingticks = 4; deadticks = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (coax_out !== '0 || busy !== 1'b0 || trig_count !== 32'd0) begin
        bad++; $display("FAIL reset_hold got coax=%h busy=%b cnt=%0d exp 0/0/0", coax_out, busy, trig_count);
      end
    end
    nrst = 1;
    cyc();
    total++;
    if (coax_out !== 16'hFFFF || trig_count !== 32'd1) begin
      bad++; $display("FAIL reset_first_fire got coax=%h cnt=%0d exp ffff/1", coax_out, trig_count);
    end
    do_reset();
  endtask

  task automatic test_coinc();
    do_reset();
    mask = 8'hFF; mult_thresh = 2; firingticks = 3; deadticks = 2; enable = 1; coax_in = 8'h01;
    cyc();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL coinc_single got busy=%b exp 0", busy); end
    coax_in = 8'h03;
    cyc();
    coax_in = 8'h00;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (coax_out !== ((i < 3) ? 16'hFFFF : 16'h0000)) begin
        bad++; $display("FAIL coinc_coax cyc=%0d got=%h exp=%h", i, coax_out, (i < 3) ? 16'hFFFF : 16'h0000);
      end
      total++;
      if (busy !== (i < 11)) begin bad++; $display("FAIL coinc_busy cyc=%0d got=%b exp=%b", i, busy, i < 11); end
      cyc();
    end
    total++;
    if (trig_count !== 32'd1) begin bad++; $display("FAIL coinc_count got=%0d exp=1", trig_count); end
  endtask

  task automatic test_mask_thresh();
    do_reset();
    mask = 8'h0F; mult_thresh = 1; coax_in = 8'hF0; firingticks = 2; deadticks = 0; enable = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL masked_busy cyc=%0d got=%b exp=0", i, busy); end
    end
    mask = 8'hFF; mult_thresh = 0; coax_in = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      cyc();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL thresh0_busy cyc=%0d got=%b exp=0", i, busy); end
    end
    total++;
    if (trig_count !== 32'd0) begin bad++; $display("FAIL mask_count got=%0d exp=0", trig_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mask = 8'hFF; mult_thresh = 1; firingticks = 0; deadticks = 0; enable = 1; coax_in = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      cyc();
      total++;
      if (coax_out !== ((i % 2 == 0) ? 16'hFFFF : 16'h0000)) begin
        bad++; $display("FAIL b2b_coax cyc=%0d got=%h exp_high=%0d", i, coax_out, i % 2 == 0);
      end
      total++;
      if (trig_count !== 32'(1 + i / 2)) begin
        bad++; $display("FAIL b2b_count cyc=%0d got=%0d exp=%0d", i, trig_count, 1 + i / 2);
      end
    end
  endtask

  task automatic test_reconfig();
    int n;
    do_reset();
    mask = 8'hFF; mult_thresh = 1; firingticks = 3; deadticks = 0; enable = 1; coax_in = 8'hFF;
    cyc();
    coax_in = 8'h00; firingticks = 10;
    n = 1;
    for (int i = 0; i < 30; i++) begin cyc(); if (coax_out === 16'hFFFF) n++; end
    total++;
    if (n !== 3) begin bad++; $display("FAIL reconfig_first got=%0d exp=3", n); end
    coax_in = 8'hFF;
    cyc();
    coax_in = 8'h00;
    n = 1;
    for (int i = 0; i < 30; i++) begin cyc(); if (coax_out === 16'hFFFF) n++; end
    total++;
    if (n !== 10) begin bad++; $display("FAIL reconfig_second got=%0d exp=10", n); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mask = 8'hFF; mult_thresh = 1; firingticks = 5; deadticks = 0; enable = 1; coax_in = 8'hFF;
    cyc();
    coax_in = 8'h00;
    cyc();
    nrst = 0;
    cyc();
    total++;
    if (coax_out !== '0 || busy !== 1'b0 || trig_count !== 32'd0) begin
      bad++; $display("FAIL midreset got coax=%h busy=%b cnt=%0d exp 0/0/0", coax_out, busy, trig_count);
    end
    nrst = 1; firingticks = 0; coax_in = 8'hFF;
    for (int i = 0; i < 4; i++) cyc();
    total++;
    if (trig_count !== 32'd2) begin bad++; $display("FAIL preclr_count got=%0d exp=2", trig_count); end
    cnt_clr = 1;
    cyc();
    cnt_clr = 0; coax_in = 8'h00;
    total++;
    if (trig_count !== 32'd1 || coax_out !== 16'hFFFF) begin
      bad++; $display("FAIL clr_fire got cnt=%0d coax=%h exp 1/ffff", trig_count, coax_out);
    end
  endtask

`ifdef TRIG_PRESCALE_EN
  task automatic test_prescale();
    do_reset();
    mask = 8'hFF; mult_thresh = 1; firingticks = 1; deadticks = 0; enable = 1; prescale = 2;
    for (int h = 1; h <= 6; h++) begin
      coax_in = 8'hFF; cyc(); coax_in = 8'h00; cyc(); cyc(); cyc();
      if (h >= 5) begin
        total++;
        if (trig_count !== 32'(h - 4)) begin
          bad++; $display("FAIL prescale hit=%0d got=%0d exp=%0d", h, trig_count, h - 4);
        end
      end
    end
    prescale = 0;
  endtask
`endif

  task automatic test_random();
    logic [NOUT-1:0] exp_c;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      coax_in = NIN'($urandom);
      mask = ($urandom_range(0, 3) == 0) ? NIN'($urandom) : '1;
      mult_thresh = CW'($urandom_range(0, 4));
      firingticks = TW'($urandom_range(0, 6));
      deadticks = TW'($urandom_range(0, 3));
      enable = $urandom_range(0, 9) != 0;
      cnt_clr = $urandom_range(0, 49) == 0;
      nrst = $urandom_range(0, 199) != 0;
      prescale = TW'($urandom_range(0, 3));
      cyc();
      exp_c = (m_fire > 0) ? '1 : '0;
      total++;
      if (coax_out !== exp_c || busy !== (m_fire > 0 || m_dead > 0) || trig_count !== 32'(m_cnt)) begin
        bad++;
        $display("FAIL random cyc=%0d got coax=%h busy=%b cnt=%0d exp coax=%h busy=%b cnt=%0d",
                 i, coax_out, busy, trig_count, exp_c, m_fire > 0 || m_dead > 0, m_cnt);
      end
    end
    nrst = 1; cnt_clr = 0; prescale = 0;
  endtask

  initial begin
    test_reset();
    test_coinc();
    test_mask_thresh();
    test_back_to_back();
    test_reconfig();
    test_reset_mid();
`ifdef TRIG_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trig_coinc.md
TRIG_COINC -- requirements
Module: trig_coinc

Interface
REQ-001 SHALL have parameter NIN, default 8: number of trigger input channels (1..32).
REQ-002 SHALL have parameter NOUT, default 16: width of trigger output bus.
REQ-003 SHALL have parameter TW, default 8: width of firing/dead tick configuration inputs.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port coax_in  input  NIN  trigger input levels, already synchronous to clk.
REQ-007 SHALL have port mask  input  NIN  channel enable; 1 = channel participates.
REQ-008 SHALL have port mult_thresh  input  CW=$clog2(NIN+1)  required coincidence multiplicity.
REQ-009 SHALL have port firingticks  input  TW  output pulse length in clk cycles.
REQ-010 SHALL have port deadticks  input  TW  dead time in units of 4 clk cycles.
REQ-011 SHALL have port enable  input  1  arm; 0 blocks new triggers only.
REQ-012 SHALL have port cnt_clr  input  1  clear trigger counter.
REQ-013 SHALL have port coax_out  output  NOUT  trigger output; all ones while firing, else 0.
REQ-014 SHALL have port busy  output  1  high in FIRING or DEAD.
REQ-015 SHALL have port trig_count  output  32  number of triggers fired.

Function
REQ-016 SHALL compute mult = popcount(coax_in & mask) combinationally each cycle.
REQ-017 SHALL define hit = enable & (mult_thresh != 0) & (mult >= mult_thresh); mult_thresh = 0 never triggers.
REQ-018 SHALL implement states IDLE, FIRING, DEAD; reset state IDLE.
REQ-019 IDLE: on hit sampled at edge N, SHALL enter FIRING at edge N, latching F = max(firingticks,1) and D = deadticks*4 (TW+2 bits, no overflow).
REQ-020 SHALL drive coax_out all ones, registered, for exactly F cycles starting the cycle after edge N (1-cycle latency).
REQ-021 FIRING -> DEAD after F cycles if D > 0, else FIRING -> IDLE directly.
REQ-022 DEAD SHALL last exactly D cycles with coax_out = 0, then return to IDLE.
REQ-023 hit SHALL be ignored in FIRING and DEAD; no queuing of triggers.
REQ-024 Level-sensitive retrigger: hit present on first IDLE cycle SHALL fire immediately.
REQ-025 Changes to firingticks/deadticks/mult_thresh/mask/enable mid-cycle SHALL NOT alter the running FIRING/DEAD durations.
REQ-026 trig_count SHALL increment by 1 on each IDLE->FIRING transition, saturating at 32'hFFFFFFFF.
REQ-027 cnt_clr SHALL set trig_count to 0 next edge; simultaneous with a fire, trig_count SHALL become 1.
REQ-028 busy SHALL be registered, aligned with state (high on the same cycles coax_out is asserted, plus DEAD).

Reset
REQ-029 nrst low at any edge SHALL force state IDLE, coax_out 0, busy 0, trig_count 0, internal counters 0, prescale counter 0; mid-pulse reset aborts the pulse the next cycle.
REQ-030 hit while nrst low SHALL be ignored; first fire possible on the edge after nrst rises.

Configuration
REQ-031 Macro TRIG_PRESCALE_EN defined: SHALL add port prescale  input  TW; only every (prescale+1)-th hit in IDLE fires; non-firing hits SHALL increment an internal prescale counter only, leave state IDLE, not count in trig_count; counter resets to 0 after each fire.
REQ-032 Macro undefined: SHALL have no prescale port; every hit in IDLE fires.

Verification
REQ-033 NIN=8, mask=FF, mult_thresh=2, firingticks=3, deadticks=2, coax_in=01 then 03 for 1 cycle -> no fire on 01; coax_out=FFFF for 3 cycles from the cycle after 03, then 8 DEAD cycles, busy high 11 cycles, trig_count=1.
REQ-034 mask=0F, mult_thresh=1, coax_in=F0 held -> never fires; mult_thresh=0 with coax_in=FF -> never fires.
REQ-035 firingticks=0, deadticks=0, coax_in=FF held -> 1-cycle pulses, FIRING->IDLE->FIRING, trig_count increments every 2 cycles.
REQ-036 firingticks changed 3->10 during FIRING -> current pulse still 3 cycles; next pulse 10 cycles.
REQ-037 nrst low at 2nd cycle of a 5-cycle pulse -> coax_out 0 next cycle, trig_count 0; cnt_clr coincident with fire -> trig_count=1.
REQ-038 TRIG_PRESCALE_EN, prescale=2, five separated hits -> fires on hits 1st... specifically 3rd only among first five? No: fires on 3rd hit and resets; trig_count=1 after 5 hits, 2 after 6th.
